// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: RAM word, RAM handshake state and the
// arbiter grant state used between the caches and the RAM model.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_I     = 2'b01,
        ARB_D     = 2'b10,
        ARB_DLOCK = 2'b11
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache priority, bounded
// icache starvation, and 2-beat dcache bursts held together via ARB_DLOCK.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      dburst,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ramerr
);

    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;

    logic d_req;
    logic i_grant;
    logic d_grant;
    logic i_done;
    logic d_done;
    arb_state_t pick;

    // Completion is suppressed during reset so neither wait can drop then.
    always_comb begin
        d_req   = dREN | dWEN;
        i_grant = (state_q == ARB_I);
        d_grant = (state_q == ARB_D) || (state_q == ARB_DLOCK);
        i_done  = !RST && i_grant && (ramstate == ACCESS) && iREN;
        d_done  = !RST && d_grant && (ramstate == ACCESS) && d_req;
    end

    // The count used for arbitration already includes this cycle's dcache
    // completion, so the icache wins right after the STARVE_MAX-th grant.
    always_comb begin
        starve_d = starve_q;
        if (!iREN || i_done) begin
            starve_d = '0;
        end else if (d_done && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        pick = ARB_IDLE;
        if (d_req && !(iREN && (starve_d == STARVE_LIM))) begin
            pick = ARB_D;
        end else if (iREN) begin
            pick = ARB_I;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: state_d = pick;
            ARB_I: begin
                if (i_done || !iREN) begin
                    state_d = pick;
                end
            end
            ARB_D: begin
                if (d_done && dburst) begin
                    state_d = ARB_DLOCK;
                end else if (d_done || !d_req) begin
                    state_d = pick;
                end
            end
            ARB_DLOCK: begin
                if (d_done || !d_req) begin
                    state_d = pick;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM enables are gated by the owner's live request so an abandoned
    // access stops driving the RAM in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramerr   = 1'b0;
        if (!RST) begin
            case (state_q)
                ARB_I: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    iload   = ramload;
                    iwait   = !i_done;
                end
                ARB_D, ARB_DLOCK: begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dload    = ramload;
                    dwait    = !d_done;
                end
                default: ;
            endcase
            ramerr = (state_q != ARB_IDLE) && (ramstate == ERROR);
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table followed by
// hand-written starvation, abort/error and mid-operation reset sequences.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dburst;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      ramerr;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.STARVE_MAX(4), .CW(3)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dburst(dburst), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .ramerr(ramerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic      rst, iren, dren, dwen, dburst;
        word_t     daddr, ramload;
        ramstate_t rs;
        logic      e_ren, e_wen;
        word_t     e_addr;
        logic      e_iw, e_dw;
        word_t     e_iload, e_dload;
        logic      e_err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mkv(
        input logic rst, input logic iren, input logic dren, input logic dwen,
        input logic dburst, input word_t da, input word_t ld, input ramstate_t rs,
        input logic e_ren, input logic e_wen, input word_t e_addr,
        input logic e_iw, input logic e_dw, input word_t e_il, input word_t e_dl,
        input logic e_err);
        vec_t r;
        r.rst = rst; r.iren = iren; r.dren = dren; r.dwen = dwen; r.dburst = dburst;
        r.daddr = da; r.ramload = ld; r.rs = rs;
        r.e_ren = e_ren; r.e_wen = e_wen; r.e_addr = e_addr;
        r.e_iw = e_iw; r.e_dw = e_dw; r.e_iload = e_il; r.e_dload = e_dl;
        r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; dburst = 1'b0;
        iaddr = 32'h200; daddr = '0; dstore = 32'hD5D5; ramload = '0; ramstate = FREE;

        //               rst i  d  w  b  daddr  ramload  rs      ren wen addr   iw dw iload  dload  err
        vecs[0]  = mkv(1, 1, 1, 0, 0, 32'h100, 32'h9999, BUSY,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[1]  = mkv(1, 1, 1, 0, 0, 32'h100, 32'h9999, BUSY,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[2]  = mkv(0, 1, 1, 0, 0, 32'h100, 32'h9999, BUSY,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[3]  = mkv(0, 1, 1, 0, 0, 32'h100, 32'h0,    BUSY,   1, 0, 32'h100, 1, 1, 32'h0, 32'h0, 0);
        vecs[4]  = mkv(0, 1, 1, 0, 0, 32'h100, 32'h0,    BUSY,   1, 0, 32'h100, 1, 1, 32'h0, 32'h0, 0);
        vecs[5]  = mkv(0, 1, 1, 0, 0, 32'h100, 32'h1111, ACCESS, 1, 0, 32'h100, 1, 0, 32'h0, 32'h1111, 0);
        vecs[6]  = mkv(0, 1, 0, 0, 0, 32'h100, 32'h0,    BUSY,   0, 0, 32'h100, 1, 1, 32'h0, 32'h0, 0);
        vecs[7]  = mkv(0, 1, 0, 0, 0, 32'h100, 32'h0,    BUSY,   1, 0, 32'h200, 1, 1, 32'h0, 32'h0, 0);
        vecs[8]  = mkv(0, 1, 0, 0, 0, 32'h100, 32'h0,    BUSY,   1, 0, 32'h200, 1, 1, 32'h0, 32'h0, 0);
        vecs[9]  = mkv(0, 1, 0, 0, 0, 32'h100, 32'h2222, ACCESS, 1, 0, 32'h200, 0, 1, 32'h2222, 32'h0, 0);
        vecs[10] = mkv(0, 0, 0, 0, 0, 32'h100, 32'h0,    FREE,   0, 0, 32'h200, 1, 1, 32'h0, 32'h0, 0);
        vecs[11] = mkv(0, 1, 1, 0, 1, 32'h100, 32'h0,    FREE,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[12] = mkv(0, 1, 1, 0, 1, 32'h100, 32'h0,    BUSY,   1, 0, 32'h100, 1, 1, 32'h0, 32'h0, 0);
        vecs[13] = mkv(0, 1, 1, 0, 1, 32'h100, 32'h3333, ACCESS, 1, 0, 32'h100, 1, 0, 32'h0, 32'h3333, 0);
        vecs[14] = mkv(0, 1, 1, 0, 0, 32'h104, 32'h4444, ACCESS, 1, 0, 32'h104, 1, 0, 32'h0, 32'h4444, 0);
        vecs[15] = mkv(0, 1, 0, 0, 0, 32'h104, 32'h0,    BUSY,   0, 0, 32'h104, 1, 1, 32'h0, 32'h0, 0);
        vecs[16] = mkv(0, 1, 0, 0, 0, 32'h104, 32'h5555, ACCESS, 1, 0, 32'h200, 0, 1, 32'h5555, 32'h0, 0);
        vecs[17] = mkv(0, 0, 0, 0, 0, 32'h104, 32'h0,    FREE,   0, 0, 32'h200, 1, 1, 32'h0, 32'h0, 0);
        vecs[18] = mkv(0, 0, 0, 0, 0, 32'h104, 32'h0,    FREE,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[19] = mkv(0, 0, 1, 1, 0, 32'h108, 32'h0,    FREE,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);
        vecs[20] = mkv(0, 0, 1, 1, 0, 32'h108, 32'h6666, ACCESS, 0, 1, 32'h108, 1, 0, 32'h0, 32'h6666, 0);
        vecs[21] = mkv(0, 0, 0, 0, 0, 32'h108, 32'h0,    FREE,   0, 0, 32'h108, 1, 1, 32'h0, 32'h0, 0);
        vecs[22] = mkv(0, 0, 0, 0, 0, 32'h108, 32'h0,    FREE,   0, 0, 32'h0,   1, 1, 32'h0, 32'h0, 0);

        for (int i = 0; i < NVEC; i++) begin
            RST = vecs[i].rst; iREN = vecs[i].iren; dREN = vecs[i].dren;
            dWEN = vecs[i].dwen; dburst = vecs[i].dburst; daddr = vecs[i].daddr;
            ramload = vecs[i].ramload; ramstate = vecs[i].rs;
            @(negedge CLK);
            checks++;
            if ({ramREN, ramWEN, ramaddr, iwait, dwait, iload, dload, ramerr} !==
                {vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_iw, vecs[i].e_dw,
                 vecs[i].e_iload, vecs[i].e_dload, vecs[i].e_err}) begin
                errors++;
                $display("FAIL vec%0d: got ren=%b wen=%b addr=%h iw=%b dw=%b il=%h dl=%h err=%b expected ren=%b wen=%b addr=%h iw=%b dw=%b il=%h dl=%h err=%b",
                         i, ramREN, ramWEN, ramaddr, iwait, dwait, iload, dload, ramerr,
                         vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_iw,
                         vecs[i].e_dw, vecs[i].e_iload, vecs[i].e_dload, vecs[i].e_err);
            end
            $display("vec%0d ramaddr=%h ramREN=%b ramWEN=%b iwait=%b dwait=%b", i, ramaddr, ramREN, ramWEN, iwait, dwait);
            if (i == 1) begin
                @(posedge CLK);
                #1;
                chk("reset_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
            end else begin
                tick();
            end
        end

        // Starvation: dcache writes back to back while the icache waits.
        iREN = 1'b1; dWEN = 1'b1; dREN = 1'b0; daddr = 32'h300; ramstate = FREE;
        tick();
        for (int k = 0; k < 4; k++) begin
            daddr = 32'h300 + 32'(4 * k);
            dstore = 32'(k + 1);
            ramstate = ACCESS;
            @(negedge CLK);
            chk($sformatf("starve_dwait%0d", k), 32'(dwait), 32'h0);
            chk($sformatf("starve_wen%0d", k), 32'(ramWEN), 32'h1);
            chk($sformatf("starve_addr%0d", k), ramaddr, 32'h300 + 32'(4 * k));
            chk($sformatf("starve_store%0d", k), ramstore, 32'(k + 1));
            $display("starve wr%0d addr=%h dwait=%b", k, ramaddr, dwait);
            tick();
        end
        ramstate = BUSY;
        @(negedge CLK);
        chk("starve_igrant_addr", ramaddr, 32'h200);
        chk("starve_igrant_ren", 32'(ramREN), 32'h1);
        chk("starve_igrant_wen", 32'(ramWEN), 32'h0);
        chk("starve_cnt_max", 32'(dut.starve_q), 32'h4);
        tick();
        ramstate = ACCESS; ramload = 32'h7777;
        @(negedge CLK);
        chk("starve_iwait", 32'(iwait), 32'h0);
        chk("starve_iload", iload, 32'h7777);
        tick();
        chk("starve_cnt_clear", 32'(dut.starve_q), 32'h0);
        $display("starve icache served, starve_cnt=%0d", dut.starve_q);
        iREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload = '0;
        tick();

        // Abort: dcache drops its read while the RAM is busy.
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("abort_ren_before", 32'(ramREN), 32'h1);
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        chk("abort_ren_drop", 32'(ramREN), 32'h0);
        tick();
        @(negedge CLK);
        chk("abort_idle_addr", ramaddr, 32'h0);
        chk("abort_idle_state", 32'(dut.state_q), 32'(ARB_IDLE));
        $display("abort ramaddr=%h state=%0d", ramaddr, dut.state_q);

        // Error while the icache is granted.
        iREN = 1'b1; ramstate = FREE;
        tick();
        ramstate = ERROR;
        @(negedge CLK);
        chk("err_pulse", 32'(ramerr), 32'h1);
        chk("err_iwait", 32'(iwait), 32'h1);
        tick();
        ramstate = BUSY;
        @(negedge CLK);
        chk("err_clear", 32'(ramerr), 32'h0);
        chk("err_grant_held", ramaddr, 32'h200);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        chk("err_retry_iwait", 32'(iwait), 32'h0);
        $display("error retry iwait=%b ramerr=%b", iwait, ramerr);
        tick();
        iREN = 1'b0; ramstate = FREE;
        tick();

        // Reset in the middle of a locked burst.
        iREN = 1'b1; dREN = 1'b1; dburst = 1'b1; daddr = 32'h500; ramstate = FREE;
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        chk("rst_beat0_dwait", 32'(dwait), 32'h0);
        tick();
        chk("rst_in_dlock", 32'(dut.state_q), 32'(ARB_DLOCK));
        chk("rst_starve_pre", 32'(dut.starve_q), 32'h1);
        RST = 1'b1; ramstate = BUSY;
        @(negedge CLK);
        chk("rst_ren_forced", 32'(ramREN), 32'h0);
        chk("rst_dwait", 32'(dwait), 32'h1);
        tick();
        chk("rst_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("rst_starve_zero", 32'(dut.starve_q), 32'h0);
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dburst = 1'b0; ramstate = FREE;
        @(negedge CLK);
        chk("rst_after_addr", ramaddr, 32'h0);
        $display("midop reset state=%0d ramaddr=%h", dut.state_q, ramaddr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
